// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port (fetch/data) memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 2;

    // Width of a counter that must hold 0..smax (never narrower than one bit).
    function automatic int starve_width(input int smax);
        return (smax < 1) ? 1 : $clog2(smax + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: data side has priority unless fetch has waited STARVE_MAX grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int STARVE_W   = 2
) (
    input  logic                if_req_s,
    input  logic                d_req_s,
    input  logic [STARVE_W-1:0] starve_cnt_s,
    output owner_e              winner_s,
    output logic                grant_valid_s
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    // Combinational priority decision with starvation override for fetch.
    always_comb begin
        winner_s      = OWN_IF;
        grant_valid_s = if_req_s | d_req_s;
        if (d_req_s && !(if_req_s && (starve_cnt_s == STARVE_LIM))) begin
            winner_s = OWN_D;
        end else begin
            winner_s = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data requests onto one single-port memory,
// one access at a time, with fixed latency from grant to acknowledge.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [63:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        if_ack,
    output logic        d_ack,
    output logic [63:0] rdata,
    output logic        busy
);

    localparam int                  STARVE_W   = starve_width(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [2:0]          LAT_LAST   = 3'(MEM_LAT - 1);

    state_e              state_r;
    owner_e              owner_r;
    logic                we_r;
    logic [2:0]          lat_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    owner_e              winner_s;
    logic                grant_valid_s;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .if_req_s      (if_req),
        .d_req_s       (d_req),
        .starve_cnt_s  (starve_cnt_r),
        .winner_s      (winner_s),
        .grant_valid_s (grant_valid_s)
    );

    // Arbiter FSM; every output is a register so the memory sees clean strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            we_r         <= 1'b0;
            lat_cnt_r    <= 3'd0;
            starve_cnt_r <= '0;
            mem_en       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 64'd0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
            rdata        <= 64'd0;
            busy         <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r   <= ACCESS;
                        busy      <= 1'b1;
                        owner_r   <= winner_s;
                        lat_cnt_r <= 3'd0;
                        mem_en    <= 1'b1;
                        if (winner_s == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wr    <= d_we;
                            we_r      <= d_we;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= 64'd0;
                            mem_wr    <= 1'b0;
                            we_r      <= 1'b0;
                        end
                        // Starvation only accrues while fetch is actually waiting.
                        if ((winner_s == OWN_IF) || !if_req) begin
                            starve_cnt_r <= '0;
                        end else if (starve_cnt_r != STARVE_LIM) begin
                            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        state_r <= RESP;
                        if (!we_r) begin
                            rdata <= mem_rdata;
                        end else begin
                            rdata <= rdata;
                        end
                        if_ack <= (owner_r == OWN_IF);
                        d_ack  <= (owner_r == OWN_D);
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory strobes and acks, negedge monitors pop and compare.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        mem_en, mem_wr, if_ack, d_ack, busy;
    logic [63:0] mem_addr, mem_wdata, rdata;

    logic        if5_req;
    logic [63:0] if5_addr, mem_rdata5, mem_addr5, mem_wdata5, rdata5;
    logic        mem_en5, mem_wr5, if_ack5, d_ack5, busy5;

    always #5 clk = ~clk;

    // Memory model: read data is the address with a fixed pattern folded in.
    assign mem_rdata  = mem_addr  ^ 64'h13;
    assign mem_rdata5 = mem_addr5 ^ 64'h13;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .if_ack(if_ack),
        .d_ack(d_ack), .rdata(rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(5), .STARVE_MAX(2)) dut5 (
        .clk(clk), .reset(reset), .if_req(if5_req), .if_addr(if5_addr),
        .d_req(1'b0), .d_we(1'b0), .d_addr(64'd0), .d_wdata(64'd0),
        .mem_rdata(mem_rdata5), .mem_en(mem_en5), .mem_wr(mem_wr5),
        .mem_addr(mem_addr5), .mem_wdata(mem_wdata5), .if_ack(if_ack5),
        .d_ack(d_ack5), .rdata(rdata5), .busy(busy5)
    );

    typedef struct {int cyc; logic wr; logic [63:0] addr; logic [63:0] wdata; logic chk_wd;} en_t;
    typedef struct {int cyc; logic is_d; logic [63:0] rdata;} ack_t;

    en_t  q_en[$];
    ack_t q_ack[$];
    ack_t q_ack5[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_en(input int c, input logic wr, input logic [63:0] a,
                           input logic [63:0] wd, input logic cw);
        en_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.wdata = wd; e.chk_wd = cw;
        q_en.push_back(e);
    endtask

    task automatic push_ack(input int c, input logic is_d, input logic [63:0] rd);
        ack_t a;
        a.cyc = c; a.is_d = is_d; a.rdata = rd;
        q_ack.push_back(a);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"},    64'(mem_en),   64'd0);
        check({tag, "_mem_wr"},    64'(mem_wr),   64'd0);
        check({tag, "_if_ack"},    64'(if_ack),   64'd0);
        check({tag, "_d_ack"},     64'(d_ack),    64'd0);
        check({tag, "_busy"},      64'(busy),     64'd0);
        check({tag, "_mem_addr"},  mem_addr,      64'd0);
        check({tag, "_mem_wdata"}, mem_wdata,     64'd0);
        check({tag, "_rdata"},     rdata,         64'd0);
    endtask

    // Monitor: every strobe/ack the DUTs present must match the head of its queue.
    always @(negedge clk) begin
        en_t  e;
        ack_t a;
        if (mem_en) begin
            if (q_en.size() == 0) begin
                check("mem_en_unexpected", 64'(mem_en), 64'd0);
            end else begin
                e = q_en.pop_front();
                check("mem_en_cycle", 64'(cyc), 64'(e.cyc));
                check("mem_addr", mem_addr, e.addr);
                check("mem_wr", 64'(mem_wr), 64'(e.wr));
                if (e.chk_wd) check("mem_wdata", mem_wdata, e.wdata);
            end
        end
        if (mem_wr) check("mem_wr_without_en", 64'(mem_en), 64'd1);
        if (if_ack || d_ack) begin
            if (q_ack.size() == 0) begin
                check("ack_unexpected", {62'd0, if_ack, d_ack}, 64'd0);
            end else begin
                a = q_ack.pop_front();
                check("ack_cycle", 64'(cyc), 64'(a.cyc));
                check("ack_owner", {62'd0, if_ack, d_ack}, {62'd0, ~a.is_d, a.is_d});
                check("ack_rdata", rdata, a.rdata);
            end
        end
        if (if_ack5 || d_ack5) begin
            if (q_ack5.size() == 0) begin
                check("ack5_unexpected", {62'd0, if_ack5, d_ack5}, 64'd0);
            end else begin
                a = q_ack5.pop_front();
                check("ack5_cycle", 64'(cyc), 64'(a.cyc));
                check("ack5_owner", {62'd0, if_ack5, d_ack5}, {62'd0, ~a.is_d, a.is_d});
                check("ack5_rdata", rdata5, a.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   c0;
        ack_t a5;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 64'd0; d_addr = 64'd0; d_wdata = 64'd0;
        if5_req = 1'b0; if5_addr = 64'd0;
        tick(2);
        check_zero("reset");
        check("reset_busy5", 64'(busy5), 64'd0);
        reset = 1'b0;
        tick(1);

        // Single fetch read.
        c0 = cyc; if_req = 1'b1; if_addr = 64'h0;
        push_en(c0 + 1, 1'b0, 64'h0, 64'd0, 1'b0);
        push_ack(c0 + 3, 1'b0, 64'h13);
        tick(3); if_req = 1'b0; tick(1);

        // Simultaneous requests: data first, then fetch.
        c0 = cyc; if_req = 1'b1; if_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        push_en(c0 + 1, 1'b0, 64'h300, 64'd0, 1'b0);
        push_ack(c0 + 3, 1'b1, 64'h313);
        push_en(c0 + 5, 1'b0, 64'h200, 64'd0, 1'b0);
        push_ack(c0 + 7, 1'b0, 64'h213);
        tick(3); d_req = 1'b0; tick(4); if_req = 1'b0; tick(1);

        // Starvation, twice: D, D, IF each round (second round proves the counter cleared).
        for (int r = 0; r < 2; r++) begin
            c0 = cyc; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            if_addr = 64'h400; d_addr = 64'h500;
            push_en(c0 + 1, 1'b0, 64'h500, 64'd0, 1'b0);
            push_ack(c0 + 3, 1'b1, 64'h513);
            push_en(c0 + 5, 1'b0, 64'h500, 64'd0, 1'b0);
            push_ack(c0 + 7, 1'b1, 64'h513);
            push_en(c0 + 9, 1'b0, 64'h400, 64'd0, 1'b0);
            push_ack(c0 + 11, 1'b0, 64'h413);
            tick(9); d_req = 1'b0; tick(2); if_req = 1'b0; tick(1);
        end

        // Store: rdata keeps the previous read value.
        c0 = cyc; d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEADBEEF;
        push_en(c0 + 1, 1'b1, 64'h100, 64'hDEADBEEF, 1'b1);
        push_ack(c0 + 3, 1'b1, 64'h413);
        tick(3); d_req = 1'b0; d_we = 1'b0; d_wdata = 64'd0; tick(1);

        // Reset in the last access cycle of a fetch: no ack, everything cleared.
        c0 = cyc; if_req = 1'b1; if_addr = 64'h40;
        push_en(c0 + 1, 1'b0, 64'h40, 64'd0, 1'b0);
        tick(2); reset = 1'b1; tick(1);
        check_zero("abort");
        reset = 1'b0; if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
        push_en(c0 + 4, 1'b0, 64'h600, 64'd0, 1'b0);
        push_ack(c0 + 6, 1'b1, 64'h613);
        tick(3); d_req = 1'b0; tick(1);

        // Reset with the starvation counter saturated: next grant must still go to data.
        c0 = cyc; if_req = 1'b1; if_addr = 64'h40; d_req = 1'b1; d_addr = 64'h700;
        push_en(c0 + 1, 1'b0, 64'h700, 64'd0, 1'b0);
        push_ack(c0 + 3, 1'b1, 64'h713);
        push_en(c0 + 5, 1'b0, 64'h700, 64'd0, 1'b0);
        tick(6); reset = 1'b1; tick(1);
        check("starve_reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        push_en(c0 + 8, 1'b0, 64'h700, 64'd0, 1'b0);
        push_ack(c0 + 10, 1'b1, 64'h713);
        push_en(c0 + 12, 1'b0, 64'h40, 64'd0, 1'b0);
        push_ack(c0 + 14, 1'b0, 64'h53);
        tick(3); d_req = 1'b0; tick(4); if_req = 1'b0; tick(1);

        // MEM_LAT=5 build: ack six cycles after the request, busy for t=1..6.
        c0 = cyc; if5_req = 1'b1; if5_addr = 64'h80;
        a5.cyc = c0 + 6; a5.is_d = 1'b0; a5.rdata = 64'h93;
        q_ack5.push_back(a5);
        for (int t = 0; t < 8; t++) begin
            check("busy5", 64'(busy5), ((t >= 1) && (t <= 6)) ? 64'd1 : 64'd0);
            if (t == 6) if5_req = 1'b0;
            tick(1);
        end

        tick(3);
        check("q_en_drained",   64'(q_en.size()),   64'd0);
        check("q_ack_drained",  64'(q_ack.size()),  64'd0);
        check("q_ack5_drained", 64'(q_ack5.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
